// File: rtl/rfq_pkg.sv
// Shared types and constants for the 74670 register-file write queue.
package rfq_pkg;

    localparam int REG_ADDR_W = 2;
    localparam int REG_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/rfq_fifo.sv
// Entry storage for pending register-file writes. The whole entry array is
// exposed so the top level can search it for read forwarding.
module rfq_fifo
    import rfq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_entry,
    input  logic                     pop,
    output entry_t                   head_entry,
    output logic [$clog2(DEPTH)-1:0] head,
    output logic [$clog2(DEPTH):0]   count,
    output entry_t [DEPTH-1:0]       entries,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] tail;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= push_entry;
    end

    assign head_entry = entries[head];
    assign full       = (count == (PW+1)'(DEPTH));
    assign empty      = (count == '0);

endmodule

// File: rtl/regfile_write_queue.sv
// Write queue in front of a 74670 4x4 register file. Queued writes are
// replayed with a setup / low strobe / hold sequence, and reads are
// forwarded from pending writes so software sees the newest value at once.
//
//   state  | meaning
//   IDLE   | nothing in flight, waiting for a queued entry
//   SETUP  | in-flight address/data presented, strobe still high
//   STROBE | strobe low for WR_CYCLES cycles
//   HOLD   | strobe high again, address/data held one more cycle
module regfile_write_queue
    import rfq_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int WR_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_addr,
    input  logic [REG_DATA_W-1:0] in_data,
    output logic                  _wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [REG_DATA_W-1:0] wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [REG_DATA_W-1:0] rf_rd_data,
    output logic [REG_DATA_W-1:0] rd_data,
    output logic                  busy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [3:0] STROBE_LOAD = 4'(WR_CYCLES - 1);

    state_t             state;
    entry_t             inflight;
    logic               inflight_vld;
    logic [3:0]         strobe_cnt;
    logic               pop;
    entry_t             in_entry;
    entry_t             head_entry;
    logic [PW-1:0]      fifo_head;
    logic [PW:0]        fifo_count;
    entry_t [DEPTH-1:0] fifo_entries;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PW-1:0]      idx;

    assign in_entry = '{addr: in_addr, data: in_data};
    assign in_ready = ~fifo_full & ~reset;
    assign pop      = ((state == IDLE) || (state == HOLD)) && !fifo_empty;
    assign busy     = (fifo_count != '0) || (state != IDLE);
    assign wr_addr  = inflight.addr;
    assign wr_data  = inflight.data;

    rfq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (in_valid & in_ready),
        .push_entry (in_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .head       (fifo_head),
        .count      (fifo_count),
        .entries    (fifo_entries),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Write sequencer; the strobe is a flop so it can never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            _wr_en       <= 1'b1;
            inflight     <= '0;
            inflight_vld <= 1'b0;
            strobe_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state        <= SETUP;
                        inflight     <= head_entry;
                        inflight_vld <= 1'b1;
                    end
                end
                SETUP: begin
                    state      <= STROBE;
                    _wr_en     <= 1'b0;
                    strobe_cnt <= STROBE_LOAD;
                end
                STROBE: begin
                    if (strobe_cnt == '0) begin
                        state  <= HOLD;
                        _wr_en <= 1'b1;
                    end else begin
                        strobe_cnt <= strobe_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (!fifo_empty) begin
                        state    <= SETUP;
                        inflight <= head_entry;
                    end else begin
                        state        <= IDLE;
                        inflight_vld <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Forwarding: in-flight entry is oldest, then FIFO head to tail; later
    // matches override earlier ones so the youngest write wins.
    always_comb begin
        rd_data = rf_rd_data;
        idx     = '0;
        if (inflight_vld && (inflight.addr == rd_addr)) rd_data = inflight.data;
        for (int i = 0; i < DEPTH; i++) begin
            idx = fifo_head + PW'(i);
            if (((PW+1)'(i) < fifo_count) && (fifo_entries[idx].addr == rd_addr))
                rd_data = fifo_entries[idx].data;
        end
    end

endmodule
